int_clk_div: RTL and testbench
==============================

INT_CLK_DIV -- requirements
Module: int_clk_div

Interface
REQ-001 Parameter WIDTH, default 8, sets the bit width of div_ratio and of the internal counter.
REQ-002 Port clk, input, 1 bit: source clock; it is driven by the divide-by-2 stage's out_clk.
REQ-003 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 Port en, input, 1 bit: run request; clk-synchronous.
REQ-005 Port div_ratio, input, WIDTH bits: divide ratio R; values 0 and 1 both mean bypass.
REQ-006 Port out_clk, output, 1 bit: divided clock, 50% duty for every R>=2.
REQ-007 Port tick, output, 1 bit: registered one-cycle pulse marking the start of each output period.

Function
REQ-008 The block SHALL use a mode register with states IDLE, BYPASS and DIV, updated on the clk posedge.
REQ-009 From IDLE with en=1, mode SHALL go to DIV if div_ratio>=2, otherwise to BYPASS.
REQ-010 The period-end edge is the posedge where cnt==R_act-1 in DIV, or every posedge in BYPASS.
REQ-011 Only at a period-end edge SHALL en=0 send mode to IDLE.
REQ-012 At a period-end edge with en=1, div_ratio SHALL be re-sampled, selecting DIV (R>=2) or BYPASS (R<2).
REQ-013 R_act (WIDTH bits) SHALL latch div_ratio on IDLE exit and at every period-end edge, and SHALL never change mid-period.
REQ-014 In DIV, cnt SHALL count 0..R_act-1 and wrap to 0, with cnt=0 on the entry edge.
REQ-015 Define H = R_act/2 for even R_act and H = (R_act-1)/2 for odd R_act.
REQ-016 Posedge flop p SHALL equal (next cnt < H) in DIV and 0 otherwise.
REQ-017 Negedge flop n SHALL capture p on every clk negedge.
REQ-018 Negedge flop g SHALL capture (mode==BYPASS) on every clk negedge.
REQ-019 out_clk SHALL equal (clk AND g) OR p OR (R_act[0] AND n), a glitch-free combination.
REQ-020 For even R, out_clk SHALL be high R/2 and low R/2 clk cycles, with rising edge at the posedge where cnt=0.
REQ-021 For odd R, out_clk SHALL be high R/2 cycles (falling at a clk negedge) and low R/2, with rising edge at the posedge where cnt=0.
REQ-022 On IDLE->DIV, out_clk SHALL rise at the entry posedge.
REQ-023 On IDLE->BYPASS or DIV->BYPASS, the first out_clk pulse SHALL come at the following clk posedge.
REQ-024 On BYPASS->DIV or BYPASS->IDLE, the clk high phase in progress SHALL complete in full.
REQ-025 No out_clk high or low phase SHALL ever be shorter than half a clk cycle.
REQ-026 tick SHALL be 1 in the cycle following each DIV period start, and every cycle while mode==BYPASS.
REQ-027 Simultaneous en=0 and a div_ratio change at a period-end edge: en=0 wins and mode goes to IDLE.

Reset
REQ-028 rst_n low SHALL asynchronously clear mode to IDLE and clear cnt, R_act, p, n, g and tick to 0.
REQ-029 While rst_n is low, out_clk SHALL be 0 and tick SHALL be 0.
REQ-030 Reset asserted mid-period SHALL force out_clk to 0 immediately; truncating that pulse is permitted.
REQ-031 After rst_n rises, the block SHALL stay in IDLE until the first posedge with en=1.

Verification (clk period 10 ns)
REQ-032 Scenario: en=1, R=4, release reset -> out_clk rises at the first posedge, 20 ns high / 20 ns low, tick every 40 ns.
REQ-033 Scenario: R=3 -> 15 ns high / 15 ns low, rising edge aligned to clk posedge, falling edge aligned to clk negedge.
REQ-034 Scenario: change R from 4 to 5 at cnt=1 -> current period completes at 40 ns, next period is 50 ns (25 ns / 25 ns).
REQ-035 Scenario: R=6, drop en at cnt=1 -> current period completes (30 ns / 30 ns), then out_clk held 0 and tick stays 0.
REQ-036 Scenario: R=1 -> out_clk equals clk one cycle after entry; then switch to R=2 -> no phase <5 ns and 20 ns periods after the period-end edge.
REQ-037 Scenario: assert rst_n low while out_clk is high, R=8 -> out_clk 0 within gate delay; restart with en=1 gives a full 40 ns first high phase.

Source files
------------

// File: rtl/int_clk_div.sv
// Integer clock divider: a 50%-duty out_clk for any ratio >= 2 and a
// glitch-free bypass path for ratios 0/1, plus a period-start tick.
module int_clk_div #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] div_ratio,
  output logic             out_clk,
  output logic             tick
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BYPASS = 2'd1,
    DIV    = 2'd2
  } mode_e;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] r_act_q, r_act_d;
  logic             p_q, p_d;
  logic             n_q, n_d;
  logic             g_q, g_d;
  logic             tick_q, tick_d;
  logic             period_end;

  // NOTE: every variable is defaulted at the top of the block, so no path
  // through the if/else tree can leave one unassigned and infer a latch.
  always_comb begin
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    r_act_d = r_act_q;

    period_end = (mode_q == BYPASS) ||
                 ((mode_q == DIV) && (cnt_q == r_act_q - ONE));

    if (mode_q == IDLE) begin
      if (en) begin
        mode_d  = (div_ratio > ONE) ? DIV : BYPASS;
        r_act_d = div_ratio;
        cnt_d   = '0;
      end
    end else if (period_end) begin
      // en=0 takes priority over any ratio change at the boundary.
      mode_d  = en ? ((div_ratio > ONE) ? DIV : BYPASS) : IDLE;
      r_act_d = div_ratio;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + ONE;
    end

    // High half is floor(R/2) cycles; odd ratios get the extra half
    // cycle from the negedge copy n.
    p_d    = (mode_d == DIV) && (cnt_d < (r_act_d >> 1));
    tick_d = (mode_d == BYPASS) || ((mode_d == DIV) && (cnt_d == '0));

    n_d = p_q;
    g_d = (mode_q == BYPASS);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its inputs regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= IDLE;
      cnt_q   <= '0;
      r_act_q <= '0;
      p_q     <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      r_act_q <= r_act_d;
      p_q     <= p_d;
      tick_q  <= tick_d;
    end
  end

  // Bypass gate and odd-ratio extension change only while clk is low,
  // so neither can clip a clk high phase.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q <= 1'b0;
      g_q <= 1'b0;
    end else begin
      n_q <= n_d;
      g_q <= g_d;
    end
  end

  assign out_clk = (clk & g_q) | p_q | (r_act_q[0] & n_q);
  assign tick    = tick_q;

endmodule

// File: tb/tb_int_clk_div.sv
// Directed bench for int_clk_div: samples out_clk once per clk half-cycle
// and compares against hand-derived divided waveforms.
module tb_int_clk_div;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] div_ratio;
  logic       out_clk;
  logic       tick;

  int n_cmp = 0;
  int n_err = 0;

  int_clk_div #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .div_ratio (div_ratio),
    .out_clk   (out_clk),
    .tick      (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected out_clk for ratio r at counter value cnt. First half of the
  // cycle (after posedge) is high for cnt < floor(r/2) plus, for odd r,
  // one extra cycle; the second half (after negedge) only for cnt < floor(r/2).
  function automatic logic exp_div(input int r, input int cnt, input bit second_half);
    int h;
    h = r / 2;
    if (second_half) return logic'(cnt < h);
    return logic'(cnt < h + (r % 2));
  endfunction

  // Hold reset with the given inputs, then release while clk is low so the
  // next posedge is the first active edge.
  task automatic start_from_reset(input logic e, input logic [7:0] r);
    rst_n     = 1'b0;
    en        = e;
    div_ratio = r;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    en        = 1'b1;
    div_ratio = 8'd4;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out_clk !== 1'b0 || tick !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold[%0d]: out_clk=%b tick=%b expected 0 0", i, out_clk, tick);
      end
    end
    en = 1'b0;
    @(negedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out_clk !== 1'b0 || tick !== 1'b0) begin
        n_err++;
        $display("FAIL idle_after_reset[%0d]: out_clk=%b tick=%b expected 0 0", i, out_clk, tick);
      end
    end
  endtask

  task automatic test_div_even;
    start_from_reset(1'b1, 8'd4);
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out_clk !== exp_div(4, c % 4, 1'b0) || tick !== logic'(c % 4 == 0)) begin
        n_err++;
        $display("FAIL div4_hi[%0d]: out_clk=%b tick=%b expected %b %b", c, out_clk, tick,
                 exp_div(4, c % 4, 1'b0), logic'(c % 4 == 0));
      end
      @(negedge clk); #1;
      n_cmp++;
      if (out_clk !== exp_div(4, c % 4, 1'b1)) begin
        n_err++;
        $display("FAIL div4_lo[%0d]: out_clk=%b expected %b", c, out_clk, exp_div(4, c % 4, 1'b1));
      end
    end
  endtask

  task automatic test_div_odd;
    start_from_reset(1'b1, 8'd3);
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out_clk !== exp_div(3, c % 3, 1'b0) || tick !== logic'(c % 3 == 0)) begin
        n_err++;
        $display("FAIL div3_hi[%0d]: out_clk=%b tick=%b expected %b %b", c, out_clk, tick,
                 exp_div(3, c % 3, 1'b0), logic'(c % 3 == 0));
      end
      @(negedge clk); #1;
      n_cmp++;
      if (out_clk !== exp_div(3, c % 3, 1'b1)) begin
        n_err++;
        $display("FAIL div3_lo[%0d]: out_clk=%b expected %b", c, out_clk, exp_div(3, c % 3, 1'b1));
      end
    end
  endtask

  // Ratio 4 -> 5 requested at cnt=1: the 4-cycle period finishes, then 5.
  task automatic test_ratio_change;
    int r, cnt;
    start_from_reset(1'b1, 8'd4);
    for (int c = 0; c < 14; c++) begin
      r   = (c < 4) ? 4 : 5;
      cnt = (c < 4) ? c : (c - 4) % 5;
      @(posedge clk); #1;
      if (c == 1) div_ratio = 8'd5;
      n_cmp++;
      if (out_clk !== exp_div(r, cnt, 1'b0) || tick !== logic'(cnt == 0)) begin
        n_err++;
        $display("FAIL r4to5_hi[%0d]: out_clk=%b tick=%b expected %b %b", c, out_clk, tick,
                 exp_div(r, cnt, 1'b0), logic'(cnt == 0));
      end
      @(negedge clk); #1;
      n_cmp++;
      if (out_clk !== exp_div(r, cnt, 1'b1)) begin
        n_err++;
        $display("FAIL r4to5_lo[%0d]: out_clk=%b expected %b", c, out_clk, exp_div(r, cnt, 1'b1));
      end
    end
  endtask

  // en dropped at cnt=1 with R=6: full 30/30 period, then silent.
  task automatic test_en_drop;
    logic e_hi, e_lo, e_tk;
    start_from_reset(1'b1, 8'd6);
    for (int c = 0; c < 10; c++) begin
      e_hi = (c < 6) ? exp_div(6, c, 1'b0) : 1'b0;
      e_lo = (c < 6) ? exp_div(6, c, 1'b1) : 1'b0;
      e_tk = logic'(c == 0);
      @(posedge clk); #1;
      if (c == 1) en = 1'b0;
      n_cmp++;
      if (out_clk !== e_hi || tick !== e_tk) begin
        n_err++;
        $display("FAIL en_drop_hi[%0d]: out_clk=%b tick=%b expected %b %b", c, out_clk, tick, e_hi, e_tk);
      end
      @(negedge clk); #1;
      n_cmp++;
      if (out_clk !== e_lo) begin
        n_err++;
        $display("FAIL en_drop_lo[%0d]: out_clk=%b expected %b", c, out_clk, e_lo);
      end
    end
  endtask

  // R=1 bypass, then R=2 (BYPASS->DIV), then R=0 (DIV->BYPASS).
  task automatic test_bypass;
    logic e_hi, e_lo, e_tk;
    start_from_reset(1'b1, 8'd1);
    for (int c = 0; c < 11; c++) begin
      if (c == 0 || c == 8) begin
        e_hi = 1'b0; e_lo = 1'b0; e_tk = 1'b1;
      end else if (c < 4 || c > 8) begin
        e_hi = 1'b1; e_lo = 1'b0; e_tk = 1'b1;
      end else begin
        e_hi = logic'(c % 2 == 0); e_lo = e_hi; e_tk = e_hi;
      end
      @(posedge clk); #1;
      if (c == 3) div_ratio = 8'd2;
      if (c == 7) div_ratio = 8'd0;
      n_cmp++;
      if (out_clk !== e_hi || tick !== e_tk) begin
        n_err++;
        $display("FAIL bypass_hi[%0d]: out_clk=%b tick=%b expected %b %b", c, out_clk, tick, e_hi, e_tk);
      end
      @(negedge clk); #1;
      n_cmp++;
      if (out_clk !== e_lo) begin
        n_err++;
        $display("FAIL bypass_lo[%0d]: out_clk=%b expected %b", c, out_clk, e_lo);
      end
    end
  endtask

  // Reset while out_clk is high with R=8, then restart for a full period.
  task automatic test_reset_mid;
    start_from_reset(1'b1, 8'd8);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (out_clk !== 1'b1) begin
      n_err++;
      $display("FAIL mid_pre_reset: out_clk=%b expected 1", out_clk);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_clk !== 1'b0 || tick !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_kill: out_clk=%b tick=%b expected 0 0", out_clk, tick);
    end
    @(negedge clk); #1 rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out_clk !== exp_div(8, c, 1'b0) || tick !== logic'(c == 0)) begin
        n_err++;
        $display("FAIL restart8_hi[%0d]: out_clk=%b tick=%b expected %b %b", c, out_clk, tick,
                 exp_div(8, c, 1'b0), logic'(c == 0));
      end
      @(negedge clk); #1;
      n_cmp++;
      if (out_clk !== exp_div(8, c, 1'b1)) begin
        n_err++;
        $display("FAIL restart8_lo[%0d]: out_clk=%b expected %b", c, out_clk, exp_div(8, c, 1'b1));
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    div_ratio = 8'd0;
    test_reset();
    test_div_even();
    test_div_odd();
    test_ratio_change();
    test_en_drop();
    test_bypass();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
